// File: rtl/step_dir_pkg.sv
// Shared types and constants for the step/direction decoder.
//   state_t : decoder FSM state encoding (also exported on the debug port)
//   DIR_FWD : i_Dir level meaning forward (+1 per step)
//   DIR_REV : i_Dir level meaning return  (-1 per step)
package step_dir_pkg;

  typedef enum logic [1:0] {
    s_Unhomed = 2'd0,
    s_Idle    = 2'd1,
    s_Moving  = 2'd2
  } state_t;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

endpackage

// File: rtl/step_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector.
// Ports:
//   i_clk_50 : block clock
//   i_rst_n  : asynchronous active-low reset (all flops clear to 0)
//   d_async  : asynchronous input level
//   sync     : synchronized level (second flop)
//   rise     : one-cycle pulse, synchronized level high and previous level low
module step_sync_edge (
  input  logic i_clk_50,
  input  logic i_rst_n,
  input  logic d_async,
  output logic sync,
  output logic rise
);

  logic meta;
  logic prev;

  always_ff @(posedge i_clk_50 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= d_async;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;

endmodule

// File: rtl/step_dir_decoder.sv
// Step/direction decoder: counts step pulses into a signed position, tracks
// homing and motion state, and optionally measures the step period.
// Optional feature macro: STEP_DIR_DECODER_PERIOD_EN enables period
// measurement (o_Period, o_PeriodValid, o_Overspeed); without it those
// outputs are tied to 0 and no period counter is built.
// Ports:
//   i_clk_50      : block clock, rising edge
//   i_rst_n       : asynchronous active-low reset
//   i_Step        : async step pulse, each rising edge is one step
//   i_Dir         : async direction, 0 forward (+1), 1 return (-1)
//   i_Home        : async home switch, active-low
//   i_ClrErr      : synchronous pulse clearing o_Overspeed
//   o_Position    : signed step position, wraps in two's complement
//   o_Period      : clocks between the last two step edges
//   o_PeriodValid : one-cycle strobe when o_Period updates (no backpressure;
//                   a consumer must capture o_Period in that cycle)
//   o_Moving      : high while in s_Moving
//   o_Done        : one-cycle strobe on s_Moving -> s_Idle
//   o_Homed       : sticky, set while home is seen
//   o_Overspeed   : sticky, set when a measured period is below MIN_PER
//   o_State       : debug view of the FSM state
module step_dir_decoder
  import step_dir_pkg::*;
#(
  parameter int POS_W     = 32,
  parameter int PER_W     = 24,
  parameter int IDLE_CLKS = 1000000,
  parameter int MIN_PER   = 2500
) (
  input  logic                    i_clk_50,
  input  logic                    i_rst_n,
  input  logic                    i_Step,
  input  logic                    i_Dir,
  input  logic                    i_Home,
  input  logic                    i_ClrErr,
  output logic signed [POS_W-1:0] o_Position,
  output logic        [PER_W-1:0] o_Period,
  output logic                    o_PeriodValid,
  output logic                    o_Moving,
  output logic                    o_Done,
  output logic                    o_Homed,
  output logic                    o_Overspeed,
  output state_t                  o_State
);

  localparam int IDLE_W = $clog2(IDLE_CLKS + 1);

  logic              step_edge;
  logic              step_level_unused;
  logic              home_active;
  logic              home_rise_unused;
  logic              dir_meta;
  logic              dir_sync;
  logic [POS_W-1:0]  pos_delta;
  logic [IDLE_W-1:0] idle_cnt;
  state_t            state;

  step_sync_edge u_step_sync (
    .i_clk_50 (i_clk_50),
    .i_rst_n  (i_rst_n),
    .d_async  (i_Step),
    .sync     (step_level_unused),
    .rise     (step_edge)
  );

  // The switch is inverted before synchronizing so a cleared synchronizer
  // reads as "home not active" right after reset.
  step_sync_edge u_home_sync (
    .i_clk_50 (i_clk_50),
    .i_rst_n  (i_rst_n),
    .d_async  (~i_Home),
    .sync     (home_active),
    .rise     (home_rise_unused)
  );

  // Direction shares the step path latency, so dir_sync is the level that
  // accompanied the step edge.
  always_ff @(posedge i_clk_50 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dir_meta <= 1'b0;
      dir_sync <= 1'b0;
    end else begin
      dir_meta <= i_Dir;
      dir_sync <= dir_meta;
    end
  end

  assign pos_delta = (dir_sync == DIR_REV) ? {POS_W{1'b1}} : POS_W'(1);

  // Home has priority over everything, including a coincident step edge.
  always_ff @(posedge i_clk_50 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= s_Unhomed;
      o_Position <= '0;
      o_Moving   <= 1'b0;
      o_Done     <= 1'b0;
      o_Homed    <= 1'b0;
      idle_cnt   <= '0;
    end else begin
      o_Done <= 1'b0;
      if (home_active) begin
        state      <= s_Idle;
        o_Position <= '0;
        o_Moving   <= 1'b0;
        o_Homed    <= 1'b1;
        idle_cnt   <= '0;
      end else begin
        if (step_edge) o_Position <= o_Position + pos_delta;
        unique case (state)
          s_Unhomed: begin
            o_Moving <= 1'b0;
          end
          s_Idle: begin
            if (step_edge) begin
              state    <= s_Moving;
              o_Moving <= 1'b1;
              idle_cnt <= '0;
            end
          end
          s_Moving: begin
            // A step edge in the expiry cycle restarts the timeout instead.
            if (step_edge) begin
              idle_cnt <= '0;
            end else if (idle_cnt == IDLE_W'(IDLE_CLKS - 1)) begin
              state    <= s_Idle;
              o_Moving <= 1'b0;
              o_Done   <= 1'b1;
            end else begin
              idle_cnt <= idle_cnt + IDLE_W'(1);
            end
          end
          default: begin
            state    <= s_Unhomed;
            o_Moving <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_State = state;

`ifdef STEP_DIR_DECODER_PERIOD_EN
  logic [PER_W-1:0] per_cnt;
  logic             have_prev;
  logic             meas_edge;

  // A period is only meaningful when the previous edge belongs to the same
  // motion: not across idle, not across home.
  assign meas_edge = step_edge && have_prev && (state != s_Idle) && !home_active;

  always_ff @(posedge i_clk_50 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      per_cnt       <= '0;
      have_prev     <= 1'b0;
      o_Period      <= '0;
      o_PeriodValid <= 1'b0;
      o_Overspeed   <= 1'b0;
    end else begin
      o_PeriodValid <= 1'b0;
      if (step_edge) begin
        per_cnt <= PER_W'(1);
      end else if (per_cnt != {PER_W{1'b1}}) begin
        per_cnt <= per_cnt + PER_W'(1);
      end
      if (meas_edge) begin
        o_Period      <= per_cnt;
        o_PeriodValid <= 1'b1;
      end
      if (home_active)            have_prev <= 1'b0;
      else if (step_edge)         have_prev <= 1'b1;
      else if (state == s_Idle)   have_prev <= 1'b0;
      // A new violation wins over a clear in the same cycle.
      o_Overspeed <= (o_Overspeed & ~i_ClrErr) |
                     (meas_edge && (per_cnt < PER_W'(MIN_PER)));
    end
  end
`else
  logic clr_err_unused;
  assign clr_err_unused = i_ClrErr;
  assign o_Period       = '0;
  assign o_PeriodValid  = 1'b0;
  assign o_Overspeed    = 1'b0;
`endif

endmodule

// File: tb/tb_step_dir_decoder.sv
module tb_step_dir_decoder;
  import step_dir_pkg::*;

  localparam int POS_W     = 8;
  localparam int PER_W     = 16;
  localparam int IDLE_CLKS = 6000;
  localparam int MIN_PER   = 2500;
  localparam int PER_MAX   = (1 << PER_W) - 1;
`ifdef STEP_DIR_DECODER_PERIOD_EN
  localparam bit PERIOD_EN = 1'b1;
`else
  localparam bit PERIOD_EN = 1'b0;
`endif

  logic                    i_clk_50;
  logic                    i_rst_n;
  logic                    i_Step;
  logic                    i_Dir;
  logic                    i_Home;
  logic                    i_ClrErr;
  logic signed [POS_W-1:0] o_Position;
  logic        [PER_W-1:0] o_Period;
  logic                    o_PeriodValid;
  logic                    o_Moving;
  logic                    o_Done;
  logic                    o_Homed;
  logic                    o_Overspeed;
  state_t                  o_State;

  step_dir_decoder #(
    .POS_W(POS_W), .PER_W(PER_W), .IDLE_CLKS(IDLE_CLKS), .MIN_PER(MIN_PER)
  ) dut (
    .i_clk_50      (i_clk_50),
    .i_rst_n       (i_rst_n),
    .i_Step        (i_Step),
    .i_Dir         (i_Dir),
    .i_Home        (i_Home),
    .i_ClrErr      (i_ClrErr),
    .o_Position    (o_Position),
    .o_Period      (o_Period),
    .o_PeriodValid (o_PeriodValid),
    .o_Moving      (o_Moving),
    .o_Done        (o_Done),
    .o_Homed       (o_Homed),
    .o_Overspeed   (o_Overspeed),
    .o_State       (o_State)
  );

  // clock / reset
  initial i_clk_50 = 1'b0;
  always #10 i_clk_50 = ~i_clk_50;

  int cyc = 0;
  int done_cnt = 0;
  always @(posedge i_clk_50) begin
    cyc <= cyc + 1;
    if (o_Done === 1'b1) done_cnt <= done_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  // reference model
  logic signed [POS_W-1:0] exp_pos;
  bit                      exp_homed;
  state_t                  exp_state;
  bit                      exp_has_prev;
  bit                      exp_ovs;
  int                      last_rise;
  logic [PER_W-1:0]        exp_q[$];

  task automatic model_reset();
    exp_pos = '0; exp_homed = 0; exp_state = s_Unhomed;
    exp_has_prev = 0; exp_ovs = 0; last_rise = 0;
    exp_q.delete();
  endtask

  // One step: rise, check latency and result, release, wait out the gap
  // (gap = clocks from this rising edge to the next one).
  task automatic do_step(input logic dir, input int gap, input bit clr);
    int per;
    bit exp_valid;
    bit viol;
    logic signed [POS_W-1:0] old_pos;
    logic [PER_W-1:0] exp_per;
    @(negedge i_clk_50);
    i_Step = 1'b1;
    i_Dir  = dir;
    per = cyc - last_rise;
    if (per > PER_MAX) per = PER_MAX;
    exp_valid = exp_has_prev && (exp_state != s_Idle);
    viol = exp_valid && (per < MIN_PER);
    if (PERIOD_EN && exp_valid) exp_q.push_back(PER_W'(per));
    old_pos = exp_pos;
    exp_pos = dir ? exp_pos - 1 : exp_pos + 1;
    if (exp_state == s_Idle) exp_state = s_Moving;
    exp_has_prev = 1;
    last_rise = cyc;
    repeat (2) @(posedge i_clk_50);
    #1;
    checks++;
    if (o_Position !== old_pos) begin
      errors++; $display("FAIL step_latency: position %0d, required %0d", o_Position, old_pos);
    end
    @(negedge i_clk_50);
    if (clr) i_ClrErr = 1'b1;
    @(posedge i_clk_50);
    #1;
    i_ClrErr = 1'b0;
    exp_ovs = (exp_ovs && !clr) || viol;
    checks++;
    if (o_Position !== exp_pos) begin
      errors++; $display("FAIL step_position: got %0d, required %0d", o_Position, exp_pos);
    end
    checks++;
    if (o_Moving !== (exp_state == s_Moving)) begin
      errors++; $display("FAIL step_moving: got %0b, required %0b", o_Moving, exp_state == s_Moving);
    end
    checks++;
    if (o_PeriodValid !== (PERIOD_EN && exp_valid)) begin
      errors++; $display("FAIL step_period_valid: got %0b, required %0b", o_PeriodValid, PERIOD_EN && exp_valid);
    end
    if (exp_q.size() > 0) begin
      exp_per = exp_q.pop_front();
      checks++;
      if (o_Period !== exp_per) begin
        errors++; $display("FAIL step_period: got %0d, required %0d", o_Period, exp_per);
      end
    end
    checks++;
    if (o_Overspeed !== (PERIOD_EN && exp_ovs)) begin
      errors++; $display("FAIL step_overspeed: got %0b, required %0b", o_Overspeed, PERIOD_EN && exp_ovs);
    end
    @(negedge i_clk_50);
    i_Step = 1'b0;
    @(posedge i_clk_50);
    #1;
    checks++;
    if (o_PeriodValid !== 1'b0) begin
      errors++; $display("FAIL period_strobe_width: got %0b, required 0", o_PeriodValid);
    end
    repeat (gap - 4) @(negedge i_clk_50);
  endtask

  task automatic do_home();
    @(negedge i_clk_50);
    i_Home = 1'b0;
    repeat (4) @(negedge i_clk_50);
    i_Home = 1'b1;
    repeat (4) @(posedge i_clk_50);
    #1;
    exp_pos = '0; exp_homed = 1; exp_state = s_Idle; exp_has_prev = 0;
    checks++;
    if (o_Position !== exp_pos || o_Homed !== 1'b1) begin
      errors++; $display("FAIL home: position %0d homed %0b, required 0 and 1", o_Position, o_Homed);
    end
    checks++;
    if (o_State !== s_Idle || o_Moving !== 1'b0) begin
      errors++; $display("FAIL home_state: state %0d moving %0b, required %0d and 0", o_State, o_Moving, s_Idle);
    end
  endtask

  task automatic pulse_clr();
    @(negedge i_clk_50);
    i_ClrErr = 1'b1;
    @(posedge i_clk_50);
    #1;
    i_ClrErr = 1'b0;
    exp_ovs = 0;
    checks++;
    if (o_Overspeed !== 1'b0) begin
      errors++; $display("FAIL clr_err: overspeed %0b, required 0", o_Overspeed);
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_Step = 1'b0; i_Dir = 1'b0; i_Home = 1'b1; i_ClrErr = 1'b0;
    model_reset();
    repeat (3) @(negedge i_clk_50);
    checks++;
    if (o_Position !== '0 || o_Period !== '0 || o_PeriodValid !== 1'b0 || o_Moving !== 1'b0 ||
        o_Done !== 1'b0 || o_Homed !== 1'b0 || o_Overspeed !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: pos %0d per %0d pv %0b mv %0b dn %0b hm %0b ov %0b, required all 0",
                         o_Position, o_Period, o_PeriodValid, o_Moving, o_Done, o_Homed, o_Overspeed);
    end
    checks++;
    if (o_State !== s_Unhomed) begin
      errors++; $display("FAIL reset_state: got %0d, required %0d", o_State, s_Unhomed);
    end
    i_rst_n = 1'b1;
    repeat (5) @(posedge i_clk_50);
    #1;
    checks++;
    if (o_Homed !== 1'b0 || o_State !== s_Unhomed) begin
      errors++; $display("FAIL post_reset: homed %0b state %0d, required 0 and %0d", o_Homed, o_State, s_Unhomed);
    end
  endtask

  task automatic test_unhomed();
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) do_step(1'b0, 20, 1'b0);
    repeat (10) @(posedge i_clk_50);
    #1;
    checks++;
    if (o_State !== s_Unhomed || done_cnt !== d0 || o_Position !== exp_pos) begin
      errors++; $display("FAIL unhomed: state %0d dones %0d pos %0d, required %0d, %0d, %0d",
                         o_State, done_cnt - d0, o_Position, s_Unhomed, 0, exp_pos);
    end
  endtask

  task automatic test_home_forward();
    do_home();
    pulse_clr();
    for (int i = 0; i < 10; i++) do_step(1'b0, 20, 1'b0);
    checks++;
    if (o_Position !== 8'sd10 || o_Homed !== 1'b1 || o_Moving !== 1'b1) begin
      errors++; $display("FAIL home_forward: pos %0d homed %0b moving %0b, required 10, 1, 1", o_Position, o_Homed, o_Moving);
    end
  endtask

  task automatic test_idle_done();
    int d0;
    do_home();
    for (int i = 0; i < 4; i++) do_step(1'b1, 30, 1'b0);
    do_step(1'b1, 6, 1'b0);
    d0 = done_cnt;
    checks++;
    if (o_Position !== -8'sd5) begin
      errors++; $display("FAIL reverse_position: got %0d, required -5", o_Position);
    end
    repeat (IDLE_CLKS - 3) @(posedge i_clk_50);
    #1;
    checks++;
    if (o_Moving !== 1'b1 || o_Done !== 1'b0) begin
      errors++; $display("FAIL idle_early: moving %0b done %0b, required 1 and 0", o_Moving, o_Done);
    end
    @(posedge i_clk_50);
    #1;
    checks++;
    if (o_Done !== 1'b1 || o_Moving !== 1'b0 || o_State !== s_Idle) begin
      errors++; $display("FAIL idle_done: done %0b moving %0b state %0d, required 1, 0, %0d", o_Done, o_Moving, o_State, s_Idle);
    end
    exp_state = s_Idle;
    exp_has_prev = 0;
    repeat (50) @(posedge i_clk_50);
    #1;
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++; $display("FAIL done_once: pulses %0d, required 1", done_cnt - d0);
    end
  endtask

  task automatic test_timeout_race();
    int d0;
    d0 = done_cnt;
    do_step(1'b0, IDLE_CLKS, 1'b0);
    do_step(1'b0, 10, 1'b0);
    checks++;
    if (done_cnt !== d0 || o_State !== s_Moving) begin
      errors++; $display("FAIL timeout_race: dones %0d state %0d, required 0 and %0d", done_cnt - d0, o_State, s_Moving);
    end
  endtask

  task automatic test_period();
    do_home();
    pulse_clr();
    for (int i = 0; i < 3; i++) do_step(1'b0, 5000, 1'b0);
    do_step(1'b0, 2000, 1'b0);
    do_step(1'b0, 10, 1'b1);
    repeat (20) @(posedge i_clk_50);
    #1;
    checks++;
    if (o_Overspeed !== PERIOD_EN) begin
      errors++; $display("FAIL overspeed_sticky: got %0b, required %0b", o_Overspeed, PERIOD_EN);
    end
    pulse_clr();
  endtask

  task automatic test_wrap();
    do_home();
    for (int i = 0; i < 127; i++) do_step(1'b0, 6, 1'b0);
    checks++;
    if (o_Position !== 8'sd127) begin
      errors++; $display("FAIL wrap_top: got %0d, required 127", o_Position);
    end
    do_step(1'b0, 6, 1'b0);
    checks++;
    if (o_Position !== -8'sd128) begin
      errors++; $display("FAIL wrap: got %0d, required -128", o_Position);
    end
  endtask

  task automatic test_home_step();
    @(negedge i_clk_50);
    i_Home = 1'b0; i_Step = 1'b1; i_Dir = 1'b0;
    repeat (3) @(posedge i_clk_50);
    #1;
    exp_pos = '0; exp_homed = 1; exp_state = s_Idle; exp_has_prev = 0;
    checks++;
    if (o_Position !== '0 || o_Homed !== 1'b1 || o_State !== s_Idle) begin
      errors++; $display("FAIL home_vs_step: pos %0d homed %0b state %0d, required 0, 1, %0d", o_Position, o_Homed, o_State, s_Idle);
    end
    @(negedge i_clk_50);
    i_Home = 1'b1; i_Step = 1'b0;
    repeat (5) @(posedge i_clk_50);
    #1;
    checks++;
    if (o_Position !== '0 || o_State !== s_Idle) begin
      errors++; $display("FAIL home_release: pos %0d state %0d, required 0 and %0d", o_Position, o_State, s_Idle);
    end
  endtask

  task automatic test_random_walk();
    for (int i = 0; i < 40; i++)
      do_step(1'($urandom_range(0, 1)), $urandom_range(5, 60), ($urandom_range(0, 3) == 0));
  endtask

  task automatic test_reset_mid_move();
    for (int i = 0; i < 3; i++) do_step(1'($urandom_range(0, 1)), 8, 1'b0);
    @(negedge i_clk_50);
    i_Step = 1'b1;
    @(posedge i_clk_50);
    #3;
    i_rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (o_Position !== '0 || o_Period !== '0 || o_PeriodValid !== 1'b0 || o_Moving !== 1'b0 ||
        o_Done !== 1'b0 || o_Homed !== 1'b0 || o_Overspeed !== 1'b0 || o_State !== s_Unhomed) begin
      errors++; $display("FAIL reset_mid_move: pos %0d per %0d pv %0b mv %0b dn %0b hm %0b ov %0b st %0d, required all 0",
                         o_Position, o_Period, o_PeriodValid, o_Moving, o_Done, o_Homed, o_Overspeed, o_State);
    end
    @(negedge i_clk_50);
    i_Step = 1'b0;
    repeat (2) @(negedge i_clk_50);
    i_rst_n = 1'b1;
    repeat (6) @(posedge i_clk_50);
    #1;
    checks++;
    if (o_Position !== '0 || o_State !== s_Unhomed || o_Moving !== 1'b0) begin
      errors++; $display("FAIL inflight_discard: pos %0d state %0d moving %0b, required 0, %0d, 0", o_Position, o_State, o_Moving, s_Unhomed);
    end
  endtask

  initial begin
    test_reset();
    test_unhomed();
    test_home_forward();
    test_idle_done();
    test_timeout_race();
    test_period();
    test_wrap();
    test_home_step();
    test_random_walk();
    test_reset_mid_move();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    repeat (95000) @(posedge i_clk_50);
    errors++;
    $display("FAIL watchdog: reached %0d cycles, required completion before", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
